// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: the stop-field FSM state
// encoding, parameter limits and the counter-width helper.
package uart_rx_pkg;

    // Stop-field checker states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int MAX_SAMPLES   = 7;
    localparam int MAX_STOP_BITS = 2;

    // Bits needed to hold the values 0..n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/stop_bit_voter.sv
// Per-stop-bit majority voter. Counts accepted oversample strobes and the ones
// among them. On the last strobe of a bit it raises bit_done for that cycle,
// with bit_ok giving the vote including the current sample, and clears itself
// ready for the next bit.
//
// Handshake: a sample is taken on every cycle where enable && sample_valid.
// There is no back-pressure; the voter accepts one sample per cycle.
module stop_bit_voter
    import uart_rx_pkg::*;
#(
    parameter int SAMPLES = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic sample_valid,
    input  logic data_in,
    output logic bit_done,
    output logic bit_ok
);

    localparam int SW = cnt_width(SAMPLES);
    localparam int OW = cnt_width(SAMPLES + 1);
    localparam logic [SW-1:0] LAST_SAMPLE = SW'(SAMPLES - 1);
    localparam logic [OW:0]   THRESHOLD   = (OW + 1)'((SAMPLES + 1) / 2);

    logic [SW-1:0] r_sample_cnt;
    logic [OW-1:0] r_ones_cnt;
    logic          w_take;
    logic          w_last;
    logic [OW:0]   w_ones_next;

    assign w_take      = enable & sample_valid;
    assign w_last      = (r_sample_cnt == LAST_SAMPLE);
    assign w_ones_next = {1'b0, r_ones_cnt} + (OW + 1)'(data_in);
    assign bit_done    = w_take & w_last;
    assign bit_ok      = (w_ones_next >= THRESHOLD);

    // Accumulate samples for the current bit; restart on clear or bit end
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_sample_cnt <= '0;
            r_ones_cnt   <= '0;
        end else if (w_take) begin
            if (w_last) begin
                r_sample_cnt <= '0;
                r_ones_cnt   <= '0;
            end else begin
                r_sample_cnt <= r_sample_cnt + SW'(1);
                r_ones_cnt   <= w_ones_next[OW-1:0];
            end
        end
    end

endmodule

// File: rtl/stop_frame_check.sv
// UART stop-field checker. Votes each of STOP_BITS stop bits over SAMPLES
// oversample strobes and reports a registered framing verdict plus a one-cycle
// done pulse. The saturating framing-error counter is compiled in only when
// STOP_CHECK_ERR_COUNT_EN is defined; otherwise err_count reads 0 and
// err_count_clear is ignored, with the port list unchanged.
//
// Handshake: start is a one-cycle strobe accepted in any state (it restarts an
// active field). sample_valid qualifies data_in and is only honoured in CHECK,
// and not on the cycle start is accepted. There is no back-pressure.
module stop_frame_check
    import uart_rx_pkg::*;
#(
    parameter int STOP_BITS = 1,
    parameter int SAMPLES   = 3,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 sample_valid,
    input  logic                 data_in,
    input  logic                 err_count_clear,
    output logic                 busy,
    output logic                 done,
    output logic                 stop_error,
    output logic [CNT_WIDTH-1:0] err_count,
    output state_t               dbg_state
);

    if (STOP_BITS < 1 || STOP_BITS > MAX_STOP_BITS) begin : g_bad_stop_bits
        $fatal(1, "stop_frame_check: STOP_BITS must be 1 or 2");
    end
    if (SAMPLES < 1 || SAMPLES > MAX_SAMPLES || (SAMPLES % 2) == 0) begin : g_bad_samples
        $fatal(1, "stop_frame_check: SAMPLES must be odd and in 1..7");
    end
    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
        $fatal(1, "stop_frame_check: CNT_WIDTH must be at least 1");
    end

    localparam int BW = cnt_width(MAX_STOP_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(STOP_BITS - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic [BW-1:0] r_bit_cnt;
    logic          r_frame_fail;
    logic          r_stop_error;
    logic          w_voter_en;
    logic          w_bit_done;
    logic          w_bit_ok;
    logic          w_enter_done;
    logic          w_frame_error;

    // Samples count only in CHECK and never on the cycle a start is taken
    assign w_voter_en    = (r_state == ST_CHECK) && !start;
    assign w_enter_done  = w_bit_done && (r_bit_cnt == LAST_BIT);
    assign w_frame_error = r_frame_fail | ~w_bit_ok;

    stop_bit_voter #(
        .SAMPLES(SAMPLES)
    ) u_voter (
        .clock        (clock),
        .reset        (reset),
        .clear        (start),
        .enable       (w_voter_en),
        .sample_valid (sample_valid),
        .data_in      (data_in),
        .bit_done     (w_bit_done),
        .bit_ok       (w_bit_ok)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; start always (re)enters CHECK
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (start) begin
                    w_next_state = ST_CHECK;
                end else if (w_enter_done) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = start ? ST_CHECK : ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the registered state
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        dbg_state = r_state;
        case (r_state)
            ST_CHECK: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

    // Stop-bit index within the field
    always_ff @(posedge clock) begin
        if (reset || start) begin
            r_bit_cnt <= '0;
        end else if (w_bit_done) begin
            if (r_bit_cnt == LAST_BIT) begin
                r_bit_cnt <= '0;
            end else begin
                r_bit_cnt <= r_bit_cnt + BW'(1);
            end
        end
    end

    // Sticky failure flag for the field in progress
    always_ff @(posedge clock) begin
        if (reset || start) begin
            r_frame_fail <= 1'b0;
        end else if (w_bit_done && !w_bit_ok) begin
            r_frame_fail <= 1'b1;
        end
    end

    // Verdict captured on entry to DONE and held until the next one
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stop_error <= 1'b0;
        end else if (w_enter_done) begin
            r_stop_error <= w_frame_error;
        end
    end

    assign stop_error = r_stop_error;

`ifdef STOP_CHECK_ERR_COUNT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] r_err_count;

    // Saturating framing-error count; clear has priority over an increment
    always_ff @(posedge clock) begin
        if (reset || err_count_clear) begin
            r_err_count <= '0;
        end else if (w_enter_done && w_frame_error && (r_err_count != CNT_MAX)) begin
            r_err_count <= r_err_count + CNT_WIDTH'(1);
        end
    end

    assign err_count = r_err_count;
`else
    logic w_unused_clear;

    assign w_unused_clear = err_count_clear;
    assign err_count      = '0;
`endif

endmodule

// File: tb/tb_stop_frame_check.sv
// Directed bench for stop_frame_check. Three instances share one stimulus bus:
// dut_a (1 stop bit, 3 samples), dut_b (2 stop bits, 3 samples) and
// dut_c (1 stop bit, 1 sample, 2-bit counter). Each test resets all three and
// checks only the instance it targets.
module tb_stop_frame_check;
    import uart_rx_pkg::*;

`ifdef STOP_CHECK_ERR_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clock;
    logic reset;
    logic start;
    logic sample_valid;
    logic data_in;
    logic err_count_clear;

    logic       a_busy, a_done, a_stop_error;
    logic [7:0] a_err_count;
    state_t     a_state;
    logic       b_busy, b_done, b_stop_error;
    logic [7:0] b_err_count;
    state_t     b_state;
    logic       c_busy, c_done, c_stop_error;
    logic [1:0] c_err_count;
    state_t     c_state;

    int vec_cnt;
    int fail_cnt;
    int a_done_seen;

    stop_frame_check #(.STOP_BITS(1), .SAMPLES(3), .CNT_WIDTH(8)) dut_a (
        .clock(clock), .reset(reset), .start(start), .sample_valid(sample_valid),
        .data_in(data_in), .err_count_clear(err_count_clear), .busy(a_busy),
        .done(a_done), .stop_error(a_stop_error), .err_count(a_err_count),
        .dbg_state(a_state)
    );

    stop_frame_check #(.STOP_BITS(2), .SAMPLES(3), .CNT_WIDTH(8)) dut_b (
        .clock(clock), .reset(reset), .start(start), .sample_valid(sample_valid),
        .data_in(data_in), .err_count_clear(err_count_clear), .busy(b_busy),
        .done(b_done), .stop_error(b_stop_error), .err_count(b_err_count),
        .dbg_state(b_state)
    );

    stop_frame_check #(.STOP_BITS(1), .SAMPLES(1), .CNT_WIDTH(2)) dut_c (
        .clock(clock), .reset(reset), .start(start), .sample_valid(sample_valid),
        .data_in(data_in), .err_count_clear(err_count_clear), .busy(c_busy),
        .done(c_done), .stop_error(c_stop_error), .err_count(c_err_count),
        .dbg_state(c_state)
    );

    // Clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Count done pulses of dut_a away from the active edge
    initial a_done_seen = 0;
    always @(negedge clock) begin
        if (a_done === 1'b1) a_done_seen++;
    end

    // Apply one cycle of inputs; outputs are observed 1ns after the edge
    task automatic drive(input logic st, input logic sv, input logic d, input logic clr);
        start           = st;
        sample_valid    = sv;
        data_in         = d;
        err_count_clear = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vec_cnt++; if (a_busy !== 1'b0) begin fail_cnt++; $display("FAIL reset_busy: got %b want 0", a_busy); end
        vec_cnt++; if (a_done !== 1'b0) begin fail_cnt++; $display("FAIL reset_done: got %b want 0", a_done); end
        vec_cnt++; if (a_stop_error !== 1'b0) begin fail_cnt++; $display("FAIL reset_stop_error: got %b want 0", a_stop_error); end
        vec_cnt++; if (a_err_count !== 8'd0) begin fail_cnt++; $display("FAIL reset_err_count: got %0d want 0", a_err_count); end
        vec_cnt++; if (a_state !== ST_IDLE) begin fail_cnt++; $display("FAIL reset_state: got %0d want %0d", a_state, ST_IDLE); end
    endtask

    // dut_a: samples 1,1,1 pass; done one cycle after the third sample
    task automatic test_single_pass();
        do_reset();
        drive(1, 0, 0, 0);
        vec_cnt++; if (a_busy !== 1'b1) begin fail_cnt++; $display("FAIL pass_busy_after_start: got %b want 1", a_busy); end
        drive(0, 1, 1, 0);
        drive(0, 1, 1, 0);
        vec_cnt++; if (a_done !== 1'b0) begin fail_cnt++; $display("FAIL pass_done_early: got %b want 0", a_done); end
        drive(0, 1, 1, 0);
        vec_cnt++; if (a_done !== 1'b1) begin fail_cnt++; $display("FAIL pass_done: got %b want 1", a_done); end
        vec_cnt++; if (a_busy !== 1'b0) begin fail_cnt++; $display("FAIL pass_busy_in_done: got %b want 0", a_busy); end
        vec_cnt++; if (a_stop_error !== 1'b0) begin fail_cnt++; $display("FAIL pass_stop_error: got %b want 0", a_stop_error); end
        drive(0, 0, 0, 0);
        vec_cnt++; if (a_done !== 1'b0) begin fail_cnt++; $display("FAIL pass_done_one_cycle: got %b want 0", a_done); end
        vec_cnt++; if (a_err_count !== 8'd0) begin fail_cnt++; $display("FAIL pass_err_count: got %0d want 0", a_err_count); end
    endtask

    // dut_b: bit0 = 1,0,1 passes, bit1 = 0,0,1 fails; then a passing frame
    task automatic test_two_bit_fail();
        do_reset();
        drive(1, 0, 0, 0);
        drive(0, 1, 1, 0);
        drive(0, 0, 1, 0);   // line high without a strobe: not counted
        drive(0, 1, 0, 0);
        drive(0, 1, 1, 0);
        vec_cnt++; if (b_busy !== 1'b1) begin fail_cnt++; $display("FAIL two_bit_busy_mid: got %b want 1", b_busy); end
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 1, 1, 0);
        vec_cnt++; if (b_done !== 1'b1) begin fail_cnt++; $display("FAIL two_bit_done: got %b want 1", b_done); end
        vec_cnt++; if (b_stop_error !== 1'b1) begin fail_cnt++; $display("FAIL two_bit_stop_error: got %b want 1", b_stop_error); end
        vec_cnt++; if (b_err_count !== (CNT_EN ? 8'd1 : 8'd0)) begin fail_cnt++; $display("FAIL two_bit_err_count: got %0d want %0d", b_err_count, (CNT_EN ? 1 : 0)); end
        drive(0, 1, 0, 0);   // strobes outside CHECK are ignored
        drive(0, 1, 0, 0);
        vec_cnt++; if (b_stop_error !== 1'b1) begin fail_cnt++; $display("FAIL two_bit_hold: got %b want 1", b_stop_error); end
        drive(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) drive(0, 1, 1, 0);
        vec_cnt++; if (b_stop_error !== 1'b0) begin fail_cnt++; $display("FAIL two_bit_pass_after: got %b want 0", b_stop_error); end
        vec_cnt++; if (b_err_count !== (CNT_EN ? 8'd1 : 8'd0)) begin fail_cnt++; $display("FAIL two_bit_count_held: got %0d want %0d", b_err_count, (CNT_EN ? 1 : 0)); end
    endtask

    // dut_a: restart after two samples; the aborted partial field has no effect
    task automatic test_restart();
        int base;
        do_reset();
        drive(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0);
        vec_cnt++; if (a_stop_error !== 1'b1) begin fail_cnt++; $display("FAIL restart_prior_fail: got %b want 1", a_stop_error); end
        drive(0, 0, 0, 0);
        base = a_done_seen;
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        drive(1, 1, 0, 0);   // restart; this strobe is dropped
        vec_cnt++; if (a_busy !== 1'b1) begin fail_cnt++; $display("FAIL restart_busy: got %b want 1", a_busy); end
        vec_cnt++; if (a_stop_error !== 1'b1) begin fail_cnt++; $display("FAIL restart_stop_error_kept: got %b want 1", a_stop_error); end
        drive(0, 1, 1, 0);
        drive(0, 1, 1, 0);
        vec_cnt++; if (a_done !== 1'b0) begin fail_cnt++; $display("FAIL restart_done_early: got %b want 0", a_done); end
        drive(0, 1, 1, 0);
        vec_cnt++; if (a_done !== 1'b1) begin fail_cnt++; $display("FAIL restart_done: got %b want 1", a_done); end
        vec_cnt++; if (a_stop_error !== 1'b0) begin fail_cnt++; $display("FAIL restart_stop_error: got %b want 0", a_stop_error); end
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        vec_cnt++; if (a_done_seen - base !== 1) begin fail_cnt++; $display("FAIL restart_done_count: got %0d want 1", a_done_seen - base); end
    endtask

    // dut_c: minimum frame, back-to-back failures, saturation, clear priority
    task automatic test_saturation();
        logic [1:0] exp_sat [5];
        exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        drive(1, 0, 0, 0);
        drive(0, 1, 1, 0);
        vec_cnt++; if (c_done !== 1'b1) begin fail_cnt++; $display("FAIL min_frame_done: got %b want 1", c_done); end
        vec_cnt++; if (c_stop_error !== 1'b0) begin fail_cnt++; $display("FAIL min_frame_stop_error: got %b want 0", c_stop_error); end
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0);   // start while in DONE goes straight to CHECK
            vec_cnt++; if (c_busy !== 1'b1) begin fail_cnt++; $display("FAIL sat_busy[%0d]: got %b want 1", i, c_busy); end
            drive(0, 1, 0, 0);
            vec_cnt++; if (c_stop_error !== 1'b1) begin fail_cnt++; $display("FAIL sat_stop_error[%0d]: got %b want 1", i, c_stop_error); end
            vec_cnt++; if (c_err_count !== (CNT_EN ? exp_sat[i] : 2'd0)) begin fail_cnt++; $display("FAIL sat_count[%0d]: got %0d want %0d", i, c_err_count, (CNT_EN ? exp_sat[i] : 2'd0)); end
        end
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 1);   // clear on the same edge as a sixth failure
        vec_cnt++; if (c_err_count !== 2'd0) begin fail_cnt++; $display("FAIL sat_clear_wins: got %0d want 0", c_err_count); end
        vec_cnt++; if (c_stop_error !== 1'b1) begin fail_cnt++; $display("FAIL sat_clear_stop_error: got %b want 1", c_stop_error); end
    endtask

    // dut_a: reset mid-CHECK, then a passing frame
    task automatic test_reset_mid();
        int base;
        do_reset();
        drive(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0);
        drive(0, 0, 0, 0);
        base = a_done_seen;
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        reset = 1'b1;
        drive(0, 1, 0, 0);
        reset = 1'b0;
        vec_cnt++; if (a_busy !== 1'b0) begin fail_cnt++; $display("FAIL mid_reset_busy: got %b want 0", a_busy); end
        vec_cnt++; if (a_stop_error !== 1'b0) begin fail_cnt++; $display("FAIL mid_reset_stop_error: got %b want 0", a_stop_error); end
        drive(0, 1, 0, 0);   // idle strobes must not finish a frame
        drive(0, 1, 0, 0);
        drive(0, 0, 0, 0);
        vec_cnt++; if (a_done_seen - base !== 0) begin fail_cnt++; $display("FAIL mid_reset_no_done: got %0d want 0", a_done_seen - base); end
        drive(1, 0, 0, 0);
        drive(0, 1, 1, 0);
        drive(0, 1, 0, 0);
        drive(0, 1, 1, 0);
        vec_cnt++; if (a_done !== 1'b1) begin fail_cnt++; $display("FAIL mid_reset_next_done: got %b want 1", a_done); end
        vec_cnt++; if (a_stop_error !== 1'b0) begin fail_cnt++; $display("FAIL mid_reset_next_stop_error: got %b want 0", a_stop_error); end
    endtask

    initial begin
        vec_cnt         = 0;
        fail_cnt        = 0;
        reset           = 1'b1;
        start           = 1'b0;
        sample_valid    = 1'b0;
        data_in         = 1'b0;
        err_count_clear = 1'b0;
        test_reset();
        test_single_pass();
        test_two_bit_fail();
        test_restart();
        test_saturation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
        $finish;
    end

endmodule
